// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: routes CPU loads/stores to a synchronous RAM or to
// on-block I/O (LED/switch port, reload timer) and returns a one-cycle ready pulse.
module data_bus_ctrl #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              timer_irq
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_DONE
    } state_t;

    localparam logic [13:0] OFF_LED   = 14'h0000;
    localparam logic [13:0] OFF_SW    = 14'h0001;
    localparam logic [13:0] OFF_TLOAD = 14'h0002;
    localparam logic [13:0] OFF_TCTRL = 14'h0003;

    state_t              state_q;
    logic                capIo_q;
    logic [13:0]         capOff_q;
    logic [RAM_AW-1:0]   capWord_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic                we_q;

    logic [15:0]         led_q,    led_d;
    logic [31:0]         count_q,  count_d;
    logic [31:0]         reload_q, reload_d;
    logic                enable_q, enable_d;
    logic                irq_q,    irq_d;

    logic                reqIo;
    logic [31:0]         ioRdVal;
    logic                ioWr;
    logic                expire;
    logic                unusedAddrBits;

    assign reqIo          = (mem_addr[31:16] == 16'hFFFF);
    assign unusedAddrBits = ^mem_addr[1:0];

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign ram_we    = we_q;
    assign ram_wdata = wdata_q;
    assign led_out   = led_q;
    assign timer_irq = irq_q;

    // The RAM sees the live request address while idle so a read can start in its request cycle.
    always_comb begin
        ram_addr = '0;
        if (reset) begin
            ram_addr = '0;
        end else if (state_q == IDLE) begin
            ram_addr = mem_addr[RAM_AW+1:2];
        end else begin
            ram_addr = capWord_q;
        end
    end

    always_comb begin
        ioRdVal = 32'h0;
        case (mem_addr[15:2])
            OFF_LED:   ioRdVal = {16'h0, led_q};
            OFF_SW:    ioRdVal = {16'h0, sw_in};
            OFF_TLOAD: ioRdVal = count_q;
            OFF_TCTRL: ioRdVal = {30'h0, irq_q, enable_q};
            default:   ioRdVal = 32'h0;
        endcase
    end

    // I/O registers commit on the edge leaving WR_DONE; software writes beat the timer's own update.
    assign ioWr   = (state_q == WR_DONE) && capIo_q;
    assign expire = enable_q && (count_q == 32'd1);

    always_comb begin
        led_d    = led_q;
        count_d  = count_q;
        reload_d = reload_q;
        enable_d = enable_q;
        irq_d    = irq_q;

        if (expire) begin
            count_d = reload_q;
        end else if (enable_q && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end

        if (ioWr && (capOff_q == OFF_TCTRL) && wdata_q[1]) begin
            irq_d = 1'b0;
        end
        if (expire) begin
            irq_d = 1'b1;
        end

        if (ioWr) begin
            case (capOff_q)
                OFF_LED:   led_d = wdata_q[15:0];
                OFF_TLOAD: begin
                    count_d  = wdata_q;
                    reload_d = wdata_q;
                end
                OFF_TCTRL: enable_d = wdata_q[0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= '0;
            count_q  <= '0;
            reload_q <= '0;
            enable_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
        end
    end

    // Access FSM; a write wins over a simultaneous read and leaves mem_rdata untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            capIo_q   <= 1'b0;
            capOff_q  <= '0;
            capWord_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    if (mem_wr) begin
                        capIo_q   <= reqIo;
                        capOff_q  <= mem_addr[15:2];
                        capWord_q <= mem_addr[RAM_AW+1:2];
                        wdata_q   <= mem_wdata;
                        we_q      <= !reqIo;
                        ready_q   <= 1'b1;
                        state_q   <= WR_DONE;
                    end else if (mem_rd) begin
                        capIo_q   <= reqIo;
                        capOff_q  <= mem_addr[15:2];
                        capWord_q <= mem_addr[RAM_AW+1:2];
                        if (reqIo) begin
                            rdata_q <= ioRdVal;
                            ready_q <= 1'b1;
                            state_q <= RD_DONE;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= ram_rdata;
                    ready_q <= 1'b1;
                    state_q <= RD_DONE;
                end
                RD_DONE, WR_DONE: begin
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: the driver queues the mem_rdata expected at
// each completion and a negedge monitor checks it whenever mem_ready pulses.
module tb_data_bus_ctrl;

    localparam int RAM_AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_addr, mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [15:0]       sw_in;
    logic [15:0]       led_out;
    logic              timer_irq;

    typedef struct {
        logic [31:0] data;
        string       name;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] lastRdata = 32'h0;
    logic        prevReady = 1'b0;
    logic [31:0] ramMem [0:(1<<RAM_AW)-1];

    data_bus_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, write on ram_we.
    always @(posedge clk) begin
        if (ram_we) ramMem[ram_addr] <= ram_wdata;
        ram_rdata <= ramMem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_ready) begin
                checkOutput("ready not back-to-back", {31'h0, prevReady}, 32'h0);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected mem_ready", 32'h1, 32'h0);
                end else begin
                    sbEntry_t e;
                    e = sbQ.pop_front();
                    checkOutput({e.name, " rdata"}, mem_rdata, e.data);
                end
            end
            prevReady = mem_ready;
        end else begin
            prevReady = 1'b0;
        end
    end

    // Issues one access starting just after a posedge; returns just after the posedge that follows mem_ready.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int expLat,
                                 input logic [31:0] expRd, input string name);
        sbEntry_t e;
        int       lat;
        logic     isRam;
        logic [31:0] a;
        a     = addr;
        isRam = (a[31:16] != 16'hFFFF);
        if (wr) begin
            e.data = lastRdata;
        end else begin
            e.data    = expRd;
            lastRdata = expRd;
        end
        e.name = name;
        sbQ.push_back(e);
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!mem_ready && lat < 10);
        checkOutput({name, " latency"}, lat, expLat);
        if (wr && isRam) begin
            checkOutput({name, " ram_we"}, {31'h0, ram_we}, 32'h1);
            checkOutput({name, " ram_addr"}, {22'h0, ram_addr}, {22'h0, a[11:2]});
            checkOutput({name, " ram_wdata"}, ram_wdata, wdata);
        end else begin
            checkOutput({name, " ram_we low"}, {31'h0, ram_we}, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        lastRdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) ramMem[i] = 32'h0;
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; sw_in = 16'h0;
        #2;
        checkOutput("reset mem_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("reset mem_rdata", mem_rdata, 32'h0);
        checkOutput("reset ram_we", {31'h0, ram_we}, 32'h0);
        checkOutput("reset ram_addr", {22'h0, ram_addr}, 32'h0);
        checkOutput("reset led_out", {16'h0, led_out}, 32'h0);
        checkOutput("reset timer_irq", {31'h0, timer_irq}, 32'h0);
        doReset();

        // RAM write then read back
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0, "ram wr 0x10");
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, "ram rd 0x10");

        // LED and switch port
        applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 32'h0001_A5A5, 1, 32'h0, "led wr");
        checkOutput("led_out value", {16'h0, led_out}, 32'h0000_A5A5);
        sw_in = 16'h1234;
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 1, 32'h0000_1234, "sw rd");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 1, 32'h0000_A5A5, "led rd");

        // Unmapped I/O offset
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0040, 32'h0, 1, 32'h0, "unmapped rd");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_0040, 32'hFFFF_FFFF, 1, 32'h0, "unmapped wr");
        checkOutput("led after unmapped wr", {16'h0, led_out}, 32'h0000_A5A5);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_000C, 32'h0, 1, 32'h0, "tctrl after unmapped");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0008, 32'h0, 1, 32'h0, "tload after unmapped");

        // Timer: load 3, enable, irq three clocks after enable lands
        applyStimulus(1'b0, 1'b1, 32'hFFFF_0008, 32'h3, 1, 32'h0, "tload wr 3");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_000C, 32'h1, 1, 32'h0, "tctrl enable");
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("timer_irq after %0d clk", k), {31'h0, timer_irq}, {31'h0, (k == 3)});
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'hFFFF_0008, 32'h0, 1, 32'h2, "count after reload");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_0008, 32'd100, 1, 32'h0, "tload wr 100");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_000C, 32'h3, 1, 32'h0, "tctrl clear irq");
        checkOutput("timer_irq cleared", {31'h0, timer_irq}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_000C, 32'h0, 1, 32'h1, "tctrl still enabled");

        // Simultaneous read and write: write wins, mem_rdata keeps previous value
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 1, 32'h0, "rd+wr 0x20");
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 2, 32'h55AA_55AA, "ram rd 0x20");

        // Reset during RD_WAIT
        mem_rd = 1'b1; mem_addr = 32'h0000_0010;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort rd mem_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("abort rd mem_rdata", mem_rdata, 32'h0);
        mem_rd = 1'b0;
        doReset();

        // Reset during WR_DONE: the RAM write must not land
        mem_wr = 1'b1; mem_addr = 32'h0000_0010; mem_wdata = 32'h1111_1111;
        @(posedge clk);
        #2;
        checkOutput("pre-abort ram_we", {31'h0, ram_we}, 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("abort wr ram_we", {31'h0, ram_we}, 32'h0);
        checkOutput("abort wr mem_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("abort led_out", {16'h0, led_out}, 32'h0);
        checkOutput("abort timer_irq", {31'h0, timer_irq}, 32'h0);
        mem_wr = 1'b0;
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, "rd after aborted wr");
        applyStimulus(1'b1, 1'b0, 32'hFFFF_000C, 32'h0, 1, 32'h0, "tctrl after reset");

        repeat (3) @(posedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
